// File: rtl/sbox_layer_sequencer_if.sv
// Block handshake and shared S-box core bus for sbox_layer_sequencer.
// master = sequencer side, slave = upstream/downstream/core side.
interface sbox_layer_sequencer_if #(
   parameter int NWORDS = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [6*NWORDS-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [6*NWORDS-1:0] out_data;
   logic                busy;
   logic [5:0]          sbox_x;
   logic [5:0]          sbox_y;

   modport master (
      input  in_valid,
      input  in_data,
      input  out_ready,
      input  sbox_y,
      output in_ready,
      output out_valid,
      output out_data,
      output busy,
      output sbox_x
   );

   modport slave (
      output in_valid,
      output in_data,
      output out_ready,
      output sbox_y,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  busy,
      input  sbox_x
   );
endinterface

// File: rtl/sbox_layer_sequencer.sv
// Serialises one substitution layer through a single external S-box core,
// one 6-bit word per clock, ascending word order.
module sbox_layer_sequencer #(
   parameter int NWORDS = 8,
   parameter bit PIPE   = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sbox_layer_sequencer_if.master bus
);
   localparam int            IW   = $clog2(NWORDS);
   localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

   generate
      if (NWORDS < 2 || NWORDS > 16) begin : g_bad_nwords
         $error("sbox_layer_sequencer: NWORDS must be in 2..16");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [5:0]    buf_q [NWORDS];
   logic [5:0]    res_q [NWORDS];
   logic [IW-1:0] issue_q;
   logic [IW-1:0] issue_nx;
   logic [IW-1:0] wb_q;
   logic          drain_q;
   logic [5:0]    pipe_q;
   logic          pipe_vld_q;
   logic [5:0]    sbox_x_q;
   logic [5:0]    sbox_x_d;
   logic          accept;
   logic          run_last;

   assign accept   = bus.in_valid & bus.in_ready;
   assign issue_nx = issue_q + IW'(1);

   // Final RUN cycle: last word lands in the result buffer this edge.
   assign run_last = PIPE ? (pipe_vld_q && wb_q == LAST)
                          : (issue_q == LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = RUN;
         end
         RUN: begin
            if (run_last) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next core input: word 0 on accept, then the following word each
   // RUN cycle, and 0 whenever nothing is being issued.
   always_comb begin
      sbox_x_d = '0;
      if (accept) begin
         sbox_x_d = bus.in_data[5:0];
      end else if (state_q == RUN && !drain_q && issue_q != LAST) begin
         sbox_x_d = buf_q[issue_nx];
      end
   end

   // Input block buffer, loaded only on acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < NWORDS; i++) begin
            buf_q[i] <= bus.in_data[6*i +: 6];
         end
      end
   end

   // Issue/writeback indices, pipe register and result buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issue_q    <= '0;
         wb_q       <= '0;
         drain_q    <= 1'b0;
         pipe_q     <= '0;
         pipe_vld_q <= 1'b0;
         sbox_x_q   <= '0;
         for (int i = 0; i < NWORDS; i++) begin
            res_q[i] <= '0;
         end
      end else begin
         sbox_x_q <= sbox_x_d;
         if (accept) begin
            issue_q    <= '0;
            wb_q       <= '0;
            drain_q    <= 1'b0;
            pipe_vld_q <= 1'b0;
         end else if (state_q == RUN) begin
            if (!drain_q) begin
               if (issue_q == LAST) begin
                  drain_q <= PIPE;
               end else begin
                  issue_q <= issue_nx;
               end
            end
            if (PIPE) begin
               pipe_q     <= bus.sbox_y;
               pipe_vld_q <= !drain_q;
               if (pipe_vld_q) begin
                  res_q[wb_q] <= pipe_q;
                  if (wb_q != LAST) begin
                     wb_q <= wb_q + IW'(1);
                  end
               end
            end else begin
               res_q[issue_q] <= bus.sbox_y;
            end
         end
      end
   end

   // Result packing: word i at bits [6i+5:6i].
   for (genvar g = 0; g < NWORDS; g++) begin : g_out
      assign bus.out_data[6*g +: 6] = res_q[g];
   end

   assign bus.in_ready  = rst_n & (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sbox_x    = sbox_x_q;
endmodule

// File: tb/tb_sbox_layer_sequencer.sv
// Directed + randomized bench for sbox_layer_sequencer (PIPE=1 and PIPE=0)
// against a GF(2^6) reference of the x^19 substitution.
module tb_sbox_layer_sequencer;
   localparam int N = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   stub  = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   sbox_layer_sequencer_if #(.NWORDS(N)) bp ();
   sbox_layer_sequencer_if #(.NWORDS(N)) bz ();

   always #5 clk = ~clk;

   // GF(2^6) multiply, field polynomial x^6+x+1.
   function automatic logic [5:0] gmul(input logic [5:0] a,
                                       input logic [5:0] b);
      logic [5:0] r;
      logic [5:0] t;
      r = '0;
      t = a;
      for (int i = 0; i < 6; i++) begin
         if (b[i]) r = r ^ t;
         t = t[5] ? ((t << 1) ^ 6'h03) : (t << 1);
      end
      return r;
   endfunction

   // External core: nineteen successive multiplications.
   function automatic logic [5:0] core_pow(input logic [5:0] x);
      logic [5:0] r;
      r = 6'h01;
      for (int i = 0; i < 19; i++) r = gmul(r, x);
      return r;
   endfunction

   // Reference S-box: x^19 = x^16 * x^2 * x by squaring.
   function automatic logic [5:0] ref_s(input logic [5:0] x);
      logic [5:0] x2, x4, x8, x16;
      x2  = gmul(x, x);
      x4  = gmul(x2, x2);
      x8  = gmul(x4, x4);
      x16 = gmul(x8, x8);
      return gmul(gmul(x16, x2), x);
   endfunction

   function automatic logic [47:0] ref_blk(input logic [47:0] d,
                                           input bit st);
      logic [47:0] r;
      logic [5:0]  w;
      r = '0;
      for (int i = 0; i < N; i++) begin
         w = d[6*i +: 6];
         r[6*i +: 6] = st ? (w ^ 6'h2A) : ref_s(w);
      end
      return r;
   endfunction

   function automatic logic [47:0] rnd48();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[47:0];
   endfunction

   assign bp.sbox_y = core_pow(bp.sbox_x);
   assign bz.sbox_y = stub ? (bz.sbox_x ^ 6'h2A) : core_pow(bz.sbox_x);

   sbox_layer_sequencer #(.NWORDS(N), .PIPE(1'b1)) u_p1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bp)
   );

   sbox_layer_sequencer #(.NWORDS(N), .PIPE(1'b0)) u_p0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bz)
   );

   function automatic logic f_ir(input bit p);
      return p ? bp.in_ready : bz.in_ready;
   endfunction
   function automatic logic f_ov(input bit p);
      return p ? bp.out_valid : bz.out_valid;
   endfunction
   function automatic logic f_busy(input bit p);
      return p ? bp.busy : bz.busy;
   endfunction
   function automatic logic [5:0] f_sx(input bit p);
      return p ? bp.sbox_x : bz.sbox_x;
   endfunction
   function automatic logic [47:0] f_od(input bit p);
      return p ? bp.out_data : bz.out_data;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit p, input logic iv,
                        input logic [47:0] d, input logic ordy);
      if (p) begin
         bp.in_valid  = iv;
         bp.in_data   = d;
         bp.out_ready = ordy;
      end else begin
         bz.in_valid  = iv;
         bz.in_data   = d;
         bz.out_ready = ordy;
      end
   endtask

   // One block from IDLE; optional out_ready backpressure with the next
   // block already offered during DONE.
   task automatic block(input bit p, input logic [47:0] d,
                        input int hold, input logic [47:0] nd);
      int          lat;
      int          lim;
      logic [47:0] e;
      logic [5:0]  ex;
      lim = N + (p ? 1 : 0);
      e   = ref_blk(d, !p && stub);
      drive(p, 1'b1, d, hold == 0);
      chk("in_ready_idle", f_ir(p), 1);
      @(posedge clk); @(negedge clk);
      drive(p, 1'b0, rnd48(), hold == 0);
      lat = 0;
      while (!f_ov(p) && lat < 40) begin
         ex = '0;
         if (lat < N) ex = d[6*lat +: 6];
         chk("sbox_x_run", f_sx(p), ex);
         chk("busy_run", f_busy(p), 1);
         chk("in_ready_run", f_ir(p), 0);
         @(posedge clk); @(negedge clk);
         lat++;
      end
      chk("latency", lat, lim);
      chk("out_data", f_od(p), e);
      chk("sbox_x_done", f_sx(p), 0);
      chk("in_ready_done", f_ir(p), 0);
      if (hold > 0) begin
         drive(p, 1'b1, nd, 1'b0);
         repeat (hold) begin
            @(posedge clk); @(negedge clk);
            chk("bp_valid", f_ov(p), 1);
            chk("bp_data", f_od(p), e);
            chk("bp_in_ready", f_ir(p), 0);
            chk("bp_busy", f_busy(p), 1);
         end
         drive(p, 1'b1, nd, 1'b1);
      end
      @(posedge clk); @(negedge clk);
      chk("hs_valid_low", f_ov(p), 0);
      chk("hs_in_ready", f_ir(p), 1);
      chk("hs_data_kept", f_od(p), e);
   endtask

   initial begin
      logic [47:0] d1;
      logic [47:0] d2;
      logic [47:0] blks [4];
      int          cnt;
      int          acc;
      int          res;
      int          cyc;
      int          last;

      // Reset with in_valid asserted: nothing may be captured.
      rst_n = 1'b0;
      drive(1'b1, 1'b1, rnd48(), 1'b1);
      drive(1'b0, 1'b1, rnd48(), 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("rst_in_ready_p1", bp.in_ready, 0);
         chk("rst_in_ready_p0", bz.in_ready, 0);
         chk("rst_busy_p1", bp.busy, 0);
      end
      drive(1'b1, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         chk("idle_in_ready", f_ir(p[0]), 1);
         chk("idle_out_valid", f_ov(p[0]), 0);
         chk("idle_busy", f_busy(p[0]), 0);
         chk("idle_sbox_x", f_sx(p[0]), 0);
         chk("idle_out_data", f_od(p[0]), 0);
      end

      // PIPE=1, real core: all-zero and all-ones words.
      block(1'b1, 48'h0, 0, 48'h0);
      chk("zero_lit", bp.out_data, 48'h0);
      block(1'b1, {8{6'h01}}, 0, 48'h0);
      chk("one_lit", bp.out_data, 48'h041041041041);

      // PIPE=0, stub core: ordering.
      stub = 1'b1;
      block(1'b0, {6'h07, 6'h06, 6'h05, 6'h04,
                   6'h03, 6'h02, 6'h01, 6'h00}, 0, 48'h0);
      chk("order_lit", bz.out_data,
          {6'h2D, 6'h2C, 6'h2F, 6'h2E, 6'h29, 6'h28, 6'h2B, 6'h2A});
      stub = 1'b0;

      // Backpressure on both variants, next block queued behind it.
      d1 = rnd48();
      d2 = rnd48();
      block(1'b1, d1, 20, d2);
      block(1'b1, d2, 0, 48'h0);
      d1 = rnd48();
      d2 = rnd48();
      block(1'b0, d1, 20, d2);
      block(1'b0, d2, 0, 48'h0);

      // Reset in the 4th RUN cycle aborts the block.
      drive(1'b1, 1'b1, rnd48(), 1'b1);
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b0, rnd48(), 1'b1);
      repeat (3) begin
         @(posedge clk); @(negedge clk);
      end
      chk("pre_abort_busy", bp.busy, 1);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("abort_busy", bp.busy, 0);
      chk("abort_valid", bp.out_valid, 0);
      chk("abort_sbox_x", bp.sbox_x, 0);
      chk("abort_in_ready", bp.in_ready, 0);
      chk("abort_out_data", bp.out_data, 0);
      rst_n = 1'b1;
      cnt = 0;
      repeat (15) begin
         @(posedge clk); @(negedge clk);
         if (bp.out_valid) cnt++;
      end
      chk("abort_no_valid", cnt, 0);
      block(1'b1, rnd48(), 0, 48'h0);

      // Back-to-back on PIPE=0 with in_valid and out_ready held high.
      for (int i = 0; i < 4; i++) blks[i] = rnd48();
      acc  = 0;
      res  = 0;
      cyc  = 0;
      last = -1;
      drive(1'b0, 1'b1, blks[0], 1'b1);
      while ((acc < 4 || res < 4) && cyc < 100) begin
         if (bz.in_valid && bz.in_ready) begin
            if (last >= 0) chk("b2b_spacing", cyc - last, 10);
            last = cyc;
            acc++;
         end
         if (bz.out_valid && res < 4) begin
            chk("b2b_result", bz.out_data, ref_blk(blks[res], 1'b0));
            res++;
         end
         @(posedge clk); @(negedge clk);
         cyc++;
         bz.in_valid = (acc < 4);
         if (acc < 4) bz.in_data = blks[acc];
      end
      chk("b2b_accepts", acc, 4);
      chk("b2b_results", res, 4);

      // Random blocks on both variants, random core choice for PIPE=0.
      for (int r = 0; r < 8; r++) begin
         stub = ($urandom_range(0, 1) == 1);
         block(r[0], rnd48(), 0, 48'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
